onehot_scan_ctrl: RTL
=====================

Name: onehot_scan_ctrl

Overview:
Sequencer that drives a 4-to-16 one-hot line-select decoder. It steps a 4-bit line index through all 16 lines once per frame and holds each enabled line's strobe for a programmable dwell time. Masked lines are skipped. It outputs the binary index, its Gray-coded form and the registered one-hot strobe. It sits between the frame-level control logic and the 16 line-select consumers.

Parameters:
DWELL_W, 8, width of the dwell-count input and the internal dwell counter.

Ports:
clk  in  1  rising-edge clock
rst  in  1  synchronous, active-high reset
start  in  1  single-cycle request to begin a frame; ignored while busy=1
stop  in  1  abort request; honoured in any state
mask  in  16  per-line enable, bit i enables line i; sampled when start is accepted
dwell  in  DWELL_W  cycles each enabled line is held; 0 is treated as 1; sampled when start is accepted
sel_idx  out  4  current line index (binary), registered
sel_gray  out  4  Gray code of sel_idx, equal to sel_idx ^ (sel_idx >> 1), registered
sel_onehot  out  16  registered one-hot strobe, equal to 1 << sel_idx while line_valid=1, else 0
line_valid  out  1  current line is enabled and being strobed
busy  out  1  frame in progress
frame_done  out  1  one-cycle pulse after the last line of a completed frame

Behaviour:
- Reset (rst=1 at a clock edge): state=IDLE; sel_idx=0, sel_gray=0, sel_onehot=0, line_valid=0, busy=0, frame_done=0; all internal counters and captured values cleared. Reset overrides every other input.
- FSM states: IDLE, SCAN, DONE.
- IDLE:
  - Outputs at their reset values, except frame_done as defined under DONE.
  - If start=1 and stop=0 at edge T: capture mask_q and dwell_q (dwell_q = max(dwell, 1)), set step=0, go to SCAN.
  - In cycle T+1: busy=1 and line 0 is presented.
  - If start=1 and stop=1 in the same cycle, stop wins and the block stays in IDLE.
- SCAN, line index = order(step), where step is a 4-bit step counter:
  - Line enabled (mask_q[idx]=1): line_valid=1, sel_onehot=1<<idx for exactly dwell_q cycles, then advance.
  - Line masked: line_valid=0, sel_onehot=0 for exactly 1 cycle, then advance. sel_idx and sel_gray still show idx.
  - Advance: step+1. When step=15 completes, go to DONE; step does not wrap within a frame.
- DONE, a single cycle:
  - frame_done=1, busy=0, sel_onehot=0, line_valid=0, sel_idx/sel_gray=0.
  - Next state is IDLE.
  - start in the DONE cycle is ignored.
- Frame length in SCAN = (number of enabled lines × dwell_q) + (number of masked lines). Examples: all lines enabled with dwell=1 gives 16 cycles; mask=0 gives 16 cycles.
- stop=1 in SCAN or DONE: at the next edge go to IDLE, with all outputs at reset values and no frame_done pulse.
- Changes to mask or dwell during a frame have no effect until the next accepted start.
- sel_onehot never has more than one bit set; it is all-zero whenever line_valid=0.
- The dwell counter is DWELL_W bits wide; a dwell of 2^DWELL_W−1 must not overflow.

Optional Feature:
GRAY_ORDER_EN
- Defined: order(step) = step ^ (step >> 1), so lines are visited 0,1,3,2,6,7,5,4,12,13,15,14,10,11,9,8. Consecutive sel_idx values differ in exactly one bit.
- Undefined: order(step) = step, so lines are visited 0..15 in ascending order.
- sel_gray always equals the Gray code of sel_idx, with or without the macro.
- Frame length, handshakes and the frame_done rules are identical in both builds.

Decomposition:
- Package scan_pkg: constants SEL_W=4 and N_LINES=16; state enum {IDLE, SCAN, DONE}; function bin2gray(4-bit).
- One sub-module, scan_line_dec: a combinational 4-to-16 one-hot decoder with an enable input; it outputs 0 when disabled. The parent registers its output into sel_onehot.

Test Plan:
- Reset and idle: hold rst=1 with start=1 for 3 cycles → all outputs 0 and busy=0. Release rst with start=0 → outputs stay 0.
- Full frame: mask=16'hFFFF, dwell=2, start pulse at cycle T → sel_onehot goes 0x0001 for T+1..T+2, 0x0002 for T+3..T+4, …, 0x8000 for T+31..T+32; frame_done=1 at T+33; busy=0 from T+33.
- Skipping: mask=16'h8001, dwell=3 → 0x0001 for 3 cycles, then 14 cycles with line_valid=0 and sel_idx stepping 1..14, then 0x8000 for 3 cycles, then frame_done. Total SCAN time 20 cycles. Also mask=0 → 16 skip cycles then frame_done.
- Dwell edge values: dwell=0 behaves exactly like dwell=1. dwell=8'hFF holds each line 255 cycles with no counter wrap.
- Abort and collisions:
  - stop at the 5th cycle of SCAN → IDLE next cycle, sel_onehot=0, no frame_done.
  - start with stop in the same cycle → no frame.
  - start while busy → ignored; the frame length is unchanged.
- GRAY_ORDER_EN build with mask=FFFF, dwell=1 → sel_idx sequence 0,1,3,2,6,7,5,4,12,13,15,14,10,11,9,8. Checker: consecutive sel_idx values have a Hamming distance of 1, and sel_gray equals bin2gray(sel_idx) every cycle.

Source files
------------

// File: rtl/scan_pkg.sv
// ============================================================================
//  Module   : scan_pkg
//  Purpose  : Shared constants, FSM state encoding and Gray-code helper for
//             the one-hot line scan controller.
//  Revision : 1.0  initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

package scan_pkg;

   localparam int SEL_W   = 4;
   localparam int N_LINES = 16;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      SCAN = 2'd1,
      DONE = 2'd2
   } state_t;

   // Reflected binary Gray code of a line index
   function automatic logic [SEL_W-1:0] bin2gray(input logic [SEL_W-1:0] b);
      return b ^ (b >> 1);
   endfunction

endpackage : scan_pkg

`default_nettype wire

// File: rtl/scan_line_dec.sv
// ============================================================================
//  Module   : scan_line_dec
//  Purpose  : Combinational 4-to-16 one-hot line decoder with enable.
//             Output is all-zero when disabled.
//  Revision : 1.0  initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module scan_line_dec
   import scan_pkg::*;
(
   input  logic [SEL_W-1:0]   i_idx,
   input  logic               i_en,
   output logic [N_LINES-1:0] o_onehot
);

   // One comparator per line keeps the decode free of priority logic
   for (genvar i = 0; i < N_LINES; i++) begin : g_line
      assign o_onehot[i] = i_en && (i_idx == SEL_W'(i));
   end

endmodule : scan_line_dec

`default_nettype wire

// File: rtl/onehot_scan_ctrl.sv
// ============================================================================
//  Module   : onehot_scan_ctrl
//  Purpose  : Steps a 4-bit line index through all 16 lines once per frame,
//             holding each enabled line's one-hot strobe for a programmable
//             dwell and skipping masked lines in a single cycle.
//  Options  : GRAY_ORDER_EN - visit lines in Gray-code order instead of
//             ascending order.
//  Revision : 1.0  initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module onehot_scan_ctrl
   import scan_pkg::*;
#(
   parameter int DWELL_W = 8
)(
   input  logic               clk,
   input  logic               rst,
   input  logic               start,
   input  logic               stop,
   input  logic [N_LINES-1:0] mask,
   input  logic [DWELL_W-1:0] dwell,
   output logic [SEL_W-1:0]   sel_idx,
   output logic [SEL_W-1:0]   sel_gray,
   output logic [N_LINES-1:0] sel_onehot,
   output logic               line_valid,
   output logic               busy,
   output logic               frame_done
);

   localparam logic [DWELL_W-1:0] c_one      = DWELL_W'(1);
   localparam logic [SEL_W-1:0]   c_last_step = SEL_W'(N_LINES - 1);

   // Map the frame step counter onto the physical line visited
   function automatic logic [SEL_W-1:0] step_order(input logic [SEL_W-1:0] s);
`ifdef GRAY_ORDER_EN
      return bin2gray(s);
`else
      return s;
`endif
   endfunction

   state_t               r_state;
   logic [SEL_W-1:0]     r_step;
   logic [DWELL_W-1:0]   r_cnt;
   logic [N_LINES-1:0]   r_mask;
   logic [DWELL_W-1:0]   r_dwell;

   logic [SEL_W-1:0]     r_sel_idx;
   logic [SEL_W-1:0]     r_sel_gray;
   logic [N_LINES-1:0]   r_sel_onehot;
   logic                 r_line_valid;
   logic                 r_busy;
   logic                 r_frame_done;

   state_t               w_state_nxt;
   logic [SEL_W-1:0]     w_step_nxt;
   logic [DWELL_W-1:0]   w_cnt_nxt;
   logic [N_LINES-1:0]   w_mask_nxt;
   logic [DWELL_W-1:0]   w_dwell_nxt;
   logic [SEL_W-1:0]     w_cur_idx;
   logic                 w_line_en;
   logic                 w_line_end;

   logic [SEL_W-1:0]     w_idx_nxt;
   logic                 w_en_nxt;
   logic [N_LINES-1:0]   w_onehot_nxt;

   // The dwell counter runs 0..dwell_q-1, so a dwell of all-ones never wraps
   assign w_cur_idx  = step_order(r_step);
   assign w_line_en  = r_mask[w_cur_idx];
   assign w_line_end = !w_line_en || (r_cnt == (r_dwell - c_one));

   // Next-state, step/dwell counters and captured frame configuration
   always_comb begin
      w_state_nxt = r_state;
      w_step_nxt  = r_step;
      w_cnt_nxt   = r_cnt;
      w_mask_nxt  = r_mask;
      w_dwell_nxt = r_dwell;
      case (r_state)
         IDLE: begin
            if (start && !stop) begin
               w_state_nxt = SCAN;
               w_step_nxt  = '0;
               w_cnt_nxt   = '0;
               w_mask_nxt  = mask;
               w_dwell_nxt = (dwell == '0) ? c_one : dwell;
            end
         end
         SCAN: begin
            if (stop) begin
               w_state_nxt = IDLE;
               w_step_nxt  = '0;
               w_cnt_nxt   = '0;
               w_mask_nxt  = '0;
               w_dwell_nxt = '0;
            end else if (w_line_end) begin
               w_cnt_nxt = '0;
               if (r_step == c_last_step) begin
                  w_state_nxt = DONE;
                  w_step_nxt  = '0;
               end else begin
                  w_step_nxt = r_step + SEL_W'(1);
               end
            end else begin
               w_cnt_nxt = r_cnt + c_one;
            end
         end
         DONE: begin
            // Single-cycle state; start here is deliberately ignored
            w_state_nxt = IDLE;
            w_step_nxt  = '0;
            w_cnt_nxt   = '0;
            w_mask_nxt  = '0;
            w_dwell_nxt = '0;
         end
         default: begin
            w_state_nxt = IDLE;
            w_step_nxt  = '0;
            w_cnt_nxt   = '0;
            w_mask_nxt  = '0;
            w_dwell_nxt = '0;
         end
      endcase
   end

   // Outputs are derived from the next state so they register in step with it
   assign w_idx_nxt = (w_state_nxt == SCAN) ? step_order(w_step_nxt) : '0;
   assign w_en_nxt  = (w_state_nxt == SCAN) && w_mask_nxt[w_idx_nxt];

   scan_line_dec u_dec (
      .i_idx    (w_idx_nxt),
      .i_en     (w_en_nxt),
      .o_onehot (w_onehot_nxt)
   );

   // State, counters, captured configuration and registered outputs
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state      <= IDLE;
         r_step       <= '0;
         r_cnt        <= '0;
         r_mask       <= '0;
         r_dwell      <= '0;
         r_sel_idx    <= '0;
         r_sel_gray   <= '0;
         r_sel_onehot <= '0;
         r_line_valid <= 1'b0;
         r_busy       <= 1'b0;
         r_frame_done <= 1'b0;
      end else begin
         r_state      <= w_state_nxt;
         r_step       <= w_step_nxt;
         r_cnt        <= w_cnt_nxt;
         r_mask       <= w_mask_nxt;
         r_dwell      <= w_dwell_nxt;
         r_sel_idx    <= w_idx_nxt;
         r_sel_gray   <= bin2gray(w_idx_nxt);
         r_sel_onehot <= w_onehot_nxt;
         r_line_valid <= w_en_nxt;
         r_busy       <= (w_state_nxt == SCAN);
         r_frame_done <= (w_state_nxt == DONE);
      end
   end

   assign sel_idx    = r_sel_idx;
   assign sel_gray   = r_sel_gray;
   assign sel_onehot = r_sel_onehot;
   assign line_valid = r_line_valid;
   assign busy       = r_busy;
   assign frame_done = r_frame_done;

endmodule : onehot_scan_ctrl

`default_nettype wire
